// File: rtl/ula_pkg.sv
// Shared definitions for the multiprocessor ULA arbiter: core opcodes,
// ULA operation codes and the arbiter state encoding.
package ula_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;
    localparam logic [7:0] OP_MOD  = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_OR   = 8'h07;
    localparam logic [7:0] OP_XOR  = 8'h08;
    localparam logic [7:0] OP_NOT  = 8'h09;
    localparam logic [7:0] OP_NOR  = 8'h0A;
    localparam logic [7:0] OP_NAND = 8'h0B;
    localparam logic [7:0] OP_XNOR = 8'h0C;

    localparam logic [3:0] ULA_INVALID = 4'h0;
    localparam logic [3:0] ULA_ADD     = 4'h1;
    localparam logic [3:0] ULA_SUB     = 4'h2;
    localparam logic [3:0] ULA_MUL     = 4'h3;
    localparam logic [3:0] ULA_DIV     = 4'h4;
    localparam logic [3:0] ULA_MOD     = 4'h5;
    localparam logic [3:0] ULA_AND     = 4'h6;
    localparam logic [3:0] ULA_OR      = 4'h7;
    localparam logic [3:0] ULA_XOR     = 4'h8;
    localparam logic [3:0] ULA_NOT     = 4'h9;
    localparam logic [3:0] ULA_NOR     = 4'hA;
    localparam logic [3:0] ULA_NAND    = 4'hB;
    localparam logic [3:0] ULA_XNOR    = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/ula_arbiter_opcode_decoder.sv
// Combinational translation of an 8-bit core opcode into the 4-bit ULA
// operation code; anything outside the known set maps to ULA_INVALID.
module opcode_decoder
    import ula_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [3:0] ula_code
);

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        ula_code = ULA_INVALID;
        case (opcode)
            OP_ADD:  ula_code = ULA_ADD;
            OP_SUB:  ula_code = ULA_SUB;
            OP_MUL:  ula_code = ULA_MUL;
            OP_DIV:  ula_code = ULA_DIV;
            OP_MOD:  ula_code = ULA_MOD;
            OP_AND:  ula_code = ULA_AND;
            OP_OR:   ula_code = ULA_OR;
            OP_XOR:  ula_code = ULA_XOR;
            OP_NOT:  ula_code = ULA_NOT;
            OP_NOR:  ula_code = ULA_NOR;
            OP_NAND: ula_code = ULA_NAND;
            OP_XNOR: ula_code = ULA_XNOR;
            default: ula_code = ULA_INVALID;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter that shares one ULA among NUM_CORES cores, launching
// each operation through a start/done handshake and returning the result.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            req,
    input  logic [NUM_CORES*8-1:0]          opcode,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] operand_a,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] operand_b,
    output logic [NUM_CORES-1:0]            grant,
    output logic [NUM_CORES-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_result,
    output logic                            resp_error,
    output logic [3:0]                      ula_operation,
    output logic [DATA_WIDTH-1:0]           ula_a,
    output logic [DATA_WIDTH-1:0]           ula_b,
    output logic                            ula_start,
    input  logic                            ula_done,
    input  logic [DATA_WIDTH-1:0]           ula_result,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_CORES);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

    arb_state_t      state, state_next;
    logic [IW-1:0]   rr_ptr, owner, pick;
    logic            pick_valid;
    logic [7:0]      pick_opcode;
    logic [3:0]      pick_code;
    logic [CW-1:0]   wait_cnt;
    logic            wait_expired;

    // First requester at or after rr_ptr: scanning offsets downward lets the
    // smallest offset overwrite the others.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_CORES]) begin
                pick       = IW'((int'(rr_ptr) + i) % NUM_CORES);
                pick_valid = 1'b1;
            end
        end
    end

    assign pick_opcode  = opcode[int'(pick)*8 +: 8];
    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    opcode_decoder u_decoder (
        .opcode   (pick_opcode),
        .ula_code (pick_code)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid)
                         state_next = (pick_code == ULA_INVALID) ? RESPOND : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (ula_done || wait_expired) state_next = RESPOND;
            RESPOND: if (|resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: every register uses non-blocking assignment so all flops update from pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            owner         <= '0;
            wait_cnt      <= '0;
            grant         <= '0;
            resp_valid    <= '0;
            resp_result   <= '0;
            resp_error    <= 1'b0;
            ula_start     <= 1'b0;
            ula_operation <= ULA_INVALID;
            ula_a         <= '0;
            ula_b         <= '0;
            busy          <= 1'b0;
        end else begin
            ula_start  <= 1'b0;
            resp_valid <= '0;
            busy       <= (state_next != IDLE);
            case (state)
                IDLE: if (pick_valid) begin
                    owner    <= pick;
                    grant    <= ONE << pick;
                    wait_cnt <= '0;
                    if (pick_code != ULA_INVALID) begin
                        ula_start     <= 1'b1;
                        ula_operation <= pick_code;
                        ula_a         <= operand_a[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        ula_b         <= operand_b[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: ;
                WAIT: begin
                    if (ula_done || wait_expired) begin
                        resp_valid    <= grant;
                        resp_result   <= ula_done ? ula_result : '0;
                        resp_error    <= !ula_done;
                        ula_operation <= ULA_INVALID;
                        ula_a         <= '0;
                        ula_b         <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESPOND: begin
                    if (|resp_valid) begin
                        grant       <= '0;
                        resp_error  <= 1'b0;
                        resp_result <= '0;
                        rr_ptr      <= (owner == IW'(NUM_CORES - 1)) ? '0 : owner + IW'(1);
                    end else begin
                        // Rejected opcode: the response goes out one cycle after entry.
                        resp_valid  <= grant;
                        resp_error  <= 1'b1;
                        resp_result <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
